microsequencer: RTL and testbench

- Control unit that drives the datapath's 20-bit control-word bus.
- Steps a fixed IF/ID/OF/EX/IP phase sequence per instruction.
- Decodes the 16-bit instruction bus that the datapath returns in the ID phase.
- Counts retired instructions. It is the control-word producer for the Datapath block, which consumes the control word.

---
 rtl/microseq_defs.sv | 31 +++
 rtl/cw_decode.sv | 24 ++
 rtl/microsequencer.sv | 88 ++++++++
 tb/tb_microsequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/microseq_defs.sv
// Shared constants for the microsequencer and its datapath: widths, state codes,
// control-word constants and the recognised opcodes.
package microseq_defs;

    localparam int CW_W  = 20;
    localparam int IW    = 16;
    localparam int ST_W  = 5;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_OF   = 3'd3,
        S_EX   = 3'd4,
        S_IP   = 3'd5,
        S_TRAP = 3'd6
    } state_t;

    localparam logic [CW_W-1:0] CW_IF    = 20'b11100000111111000000;
    localparam logic [CW_W-1:0] CW_ID    = 20'b00000000000000000000;
    localparam logic [CW_W-1:0] CW_OF_SL = 20'b11111001110110000000;
    localparam logic [CW_W-1:0] CW_EX_SL = 20'b11011101000110000000;
    localparam logic [CW_W-1:0] CW_OF_SH = 20'b10101011110110000000;
    localparam logic [CW_W-1:0] CW_EX_SH = 20'b11111101001010001101;
    localparam logic [CW_W-1:0] CW_IP    = 20'b11101100111010000100;

    localparam logic [3:0]    OPC_SET  = 4'b0101;
    localparam logic [IW-1:0] NOP_INSN = 16'h0000;

endpackage

// File: rtl/cw_decode.sv
// Combinational map from (state, kind) to the datapath control word.
// The fetch word is suppressed while instruction memory is stalling.
module cw_decode
    import microseq_defs::*;
(
    input  state_t          state,
    input  logic            kind,
    input  logic            mem_wait,
    output logic [CW_W-1:0] ctrlword
);

    always_comb begin
        ctrlword = '0;
        case (state)
            S_IF:    ctrlword = mem_wait ? '0 : CW_IF;
            S_ID:    ctrlword = CW_ID;
            S_OF:    ctrlword = kind ? CW_OF_SH : CW_OF_SL;
            S_EX:    ctrlword = kind ? CW_EX_SH : CW_EX_SL;
            S_IP:    ctrlword = CW_IP;
            default: ctrlword = '0;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Phase sequencer (IF/ID/OF/EX/IP) driving the datapath control word and counting
// retired instructions. Define MICROSEQ_TRAP_EN to trap on illegal opcodes.
module microsequencer
    import microseq_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    instruction,
    input  logic [ST_W-1:0]  status,
    input  logic             mem_wait,
    output logic [CW_W-1:0]  ctrlword,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] retired,
    output logic             trap
);

    state_t            state;
    state_t            state_next;
    logic              kind;
    logic [CNT_W-1:0]  retired_cnt;
    logic              is_set;
    logic              status_unused;

    // Datapath flags are reserved in this revision.
    assign status_unused = ^status;
    assign is_set        = (instruction[IW-1:IW-4] == OPC_SET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            kind        <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_ID && is_set)
                kind <= instruction[11];
            if (state == S_IP)
                retired_cnt <= retired_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_IF;
            S_IF:   if (!mem_wait) state_next = S_ID;
            S_ID: begin
                if (instruction == NOP_INSN)
                    state_next = S_IP;
                else if (is_set)
                    state_next = S_OF;
                else
`ifdef MICROSEQ_TRAP_EN
                    state_next = S_TRAP;
`else
                    state_next = S_IP;
`endif
            end
            S_OF:   state_next = S_EX;
            S_EX:   state_next = S_IP;
            S_IP:   state_next = S_IF;
`ifdef MICROSEQ_TRAP_EN
            S_TRAP: state_next = S_TRAP;
`else
            S_TRAP: state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        phase   = state;
        retired = retired_cnt;
`ifdef MICROSEQ_TRAP_EN
        trap    = (state == S_TRAP);
`else
        trap    = 1'b0;
`endif
    end

    cw_decode u_cw_decode (
        .state    (state),
        .kind     (kind),
        .mem_wait (mem_wait),
        .ctrlword (ctrlword)
    );

endmodule

// File: tb/tb_microsequencer.sv
// Directed testbench for microsequencer; expected control words are written out
// as literals. Honours MICROSEQ_TRAP_EN for the illegal-opcode scenario.
module tb_microsequencer;

    localparam logic [19:0] E_IF    = 20'b11100000111111000000;
    localparam logic [19:0] E_OF_SL = 20'b11111001110110000000;
    localparam logic [19:0] E_EX_SL = 20'b11011101000110000000;
    localparam logic [19:0] E_OF_SH = 20'b10101011110110000000;
    localparam logic [19:0] E_EX_SH = 20'b11111101001010001101;
    localparam logic [19:0] E_IP    = 20'b11101100111010000100;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [4:0]  status;
    logic        mem_wait;
    logic [19:0] ctrlword;
    logic [2:0]  phase;
    logic [15:0] retired;
    logic        trap;

    int vectors;
    int miscompares;

    microsequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .mem_wait    (mem_wait),
        .ctrlword    (ctrlword),
        .phase       (phase),
        .retired     (retired),
        .trap        (trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({ctrlword, phase, retired, trap} !== {20'd0, 3'd0, 16'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset: cw=%b phase=%0d retired=%0d trap=%b, want all zero",
                     ctrlword, phase, retired, trap);
        end
        reset = 1'b0;
        vectors++;
        if (phase !== 3'd0 || ctrlword !== 20'd0) begin
            miscompares++;
            $display("[TB] FAIL idle: phase=%0d cw=%b, want phase 0 cw 0", phase, ctrlword);
        end
    endtask

    task automatic test_setlow();
        logic [2:0]  ep [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [19:0] ec [5] = '{E_IF, 20'd0, E_OF_SL, E_EX_SL, E_IP};
        instruction = 16'h5140;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (phase !== ep[i] || ctrlword !== ec[i]) begin
                miscompares++;
                $display("[TB] FAIL setlow step %0d: phase=%0d cw=%b, want phase=%0d cw=%b",
                         i, phase, ctrlword, ep[i], ec[i]);
            end
            if (i == 2) instruction = 16'hFFFF;
        end
        vectors++;
        if (retired !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL setlow retired-in-IP: got %0d want 0", retired);
        end
        tick();
        vectors++;
        if (retired !== 16'd1 || phase !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL setlow retire: retired=%0d phase=%0d, want 1 and 1", retired, phase);
        end
    endtask

    task automatic test_sethi();
        logic [2:0]  ep [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
        logic [19:0] ec [4] = '{20'd0, E_OF_SH, E_EX_SH, E_IP};
        instruction = 16'h5A01;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) mem_wait = 1'b1;
            vectors++;
            if (phase !== ep[i] || ctrlword !== ec[i]) begin
                miscompares++;
                $display("[TB] FAIL sethi step %0d: phase=%0d cw=%b, want phase=%0d cw=%b",
                         i, phase, ctrlword, ep[i], ec[i]);
            end
        end
        mem_wait = 1'b0;
        tick();
        vectors++;
        if (retired !== 16'd2 || phase !== 3'd1 || ctrlword !== E_IF) begin
            miscompares++;
            $display("[TB] FAIL sethi retire: retired=%0d phase=%0d cw=%b, want 2, 1, %b",
                     retired, phase, ctrlword, E_IF);
        end
    endtask

    task automatic test_mem_wait();
        logic [2:0]  ep [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd5};
        logic [19:0] ec [6] = '{20'd0, 20'd0, 20'd0, E_IF, 20'd0, E_IP};
        instruction = 16'h0000;
        mem_wait    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (i == 3) mem_wait = 1'b0;
            #1;
            vectors++;
            if (phase !== ep[i] || ctrlword !== ec[i]) begin
                miscompares++;
                $display("[TB] FAIL wait step %0d: phase=%0d cw=%b, want phase=%0d cw=%b",
                         i, phase, ctrlword, ep[i], ec[i]);
            end
        end
        tick();
        vectors++;
        if (retired !== 16'd3 || phase !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL wait retire: retired=%0d phase=%0d, want 3 and 1", retired, phase);
        end
    endtask

    task automatic test_wrap();
        force dut.retired_cnt = 16'hFFFF;
        #1;
        release dut.retired_cnt;
        #1;
        vectors++;
        if (retired !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL wrap preload: got %h want ffff", retired);
        end
        instruction = 16'h0000;
        tick();
        tick();
        tick();
        vectors++;
        if (retired !== 16'h0000 || phase !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap: retired=%h phase=%0d, want 0000 and 1", retired, phase);
        end
    endtask

    task automatic test_illegal();
        instruction = 16'hF000;
        tick();
        tick();
`ifdef MICROSEQ_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (trap !== 1'b1 || phase !== 3'd6 || ctrlword !== 20'd0 || retired !== 16'd0) begin
                miscompares++;
                $display("[TB] FAIL trap cycle %0d: trap=%b phase=%0d cw=%b retired=%0d, want 1 6 0 0",
                         i, trap, phase, ctrlword, retired);
            end
            tick();
        end
`else
        vectors++;
        if (trap !== 1'b0 || phase !== 3'd5 || ctrlword !== E_IP) begin
            miscompares++;
            $display("[TB] FAIL illegal-as-nop: trap=%b phase=%0d cw=%b, want 0 5 %b",
                     trap, phase, ctrlword, E_IP);
        end
        tick();
        vectors++;
        if (retired !== 16'd1 || phase !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL illegal retire: retired=%0d phase=%0d, want 1 and 1", retired, phase);
        end
`endif
    endtask

    task automatic test_reset_abort();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        instruction = 16'h5140;
        tick();
        tick();
        tick();
        vectors++;
        if (phase !== 3'd3 || ctrlword !== E_OF_SL) begin
            miscompares++;
            $display("[TB] FAIL abort pre: phase=%0d cw=%b, want 3 %b", phase, ctrlword, E_OF_SL);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (phase !== 3'd0 || ctrlword !== 20'd0 || retired !== 16'd0 || trap !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort async: phase=%0d cw=%b retired=%0d trap=%b, want all zero",
                     phase, ctrlword, retired, trap);
        end
        tick();
        reset = 1'b0;
        vectors++;
        if (phase !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL abort idle: phase=%0d want 0", phase);
        end
        tick();
        vectors++;
        if (phase !== 3'd1 || ctrlword !== E_IF || retired !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL abort restart: phase=%0d cw=%b retired=%0d, want 1 %b 0",
                     phase, ctrlword, retired, E_IF);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        instruction = 16'h0000;
        status      = 5'h1F;
        mem_wait    = 1'b0;
        tick();
        test_reset();
        test_setlow();
        test_sethi();
        test_mem_wait();
        test_wrap();
        test_illegal();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
